// File: rtl/freq_meter.sv
// Gated frequency meter: synchronizes an asynchronous input, counts its rising edges over
// back-to-back windows of GATE_CYCLES clocks and publishes one saturating count per window.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_out,
  output logic               freq_valid,
  output logic               overflow,
  output logic [1:0]         dbg_state_o
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]  GATE_ONE  = GATE_W'(1);
  localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(SYNC_STAGES);
  localparam logic [ARM_W-1:0]   ARM_ONE   = ARM_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_COUNT = 2'd1
  } state_e;

  // Handshake: none. freq_valid is a pure 1-cycle strobe with no back-pressure;
  // freq_out/overflow are stable from that strobe until the next one.

  state_e               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic [ARM_W-1:0]     arm_q;
  logic [GATE_W-1:0]    gate_q;
  logic [COUNT_W-1:0]   edge_cnt_q;
  logic                 sat_q;
  logic [COUNT_W-1:0]   freq_q;
  logic                 valid_q;
  logic                 ovf_q;

  logic                 edge_det;
  logic                 cnt_full;
  logic                 gate_last;
  logic [COUNT_W-1:0]   edge_cnt_d;
  logic                 sat_d;

  // Input synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    edge_det   = sync_q[SYNC_STAGES-1] & ~hist_q;
    cnt_full   = (edge_cnt_q == CNT_MAX);
    gate_last  = (gate_q == GATE_LAST);
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (edge_det) begin
      if (cnt_full) begin
        sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_ONE;
      end
    end
  end

  // Control FSM; the terminal cycle's own edge is folded in through edge_cnt_d/sat_d.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_ARM;
      arm_q      <= '0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_ARM: begin
          gate_q     <= '0;
          edge_cnt_q <= '0;
          sat_q      <= 1'b0;
          if (arm_q == ARM_LAST) begin
            arm_q   <= '0;
            state_q <= ST_COUNT;
          end else begin
            arm_q <= arm_q + ARM_ONE;
          end
        end
        ST_COUNT: begin
          if (gate_last) begin
            freq_q     <= edge_cnt_d;
            ovf_q      <= sat_d;
            valid_q    <= 1'b1;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end else begin
            gate_q     <= gate_q + GATE_ONE;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
          end
        end
        default: begin
          state_q <= ST_ARM;
          arm_q   <= '0;
        end
      endcase
    end
  end

  assign freq_out    = freq_q;
  assign freq_valid  = valid_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: records the input trace per clock and derives each window's
// expected count from the recorded rising transitions.
module tb_freq_meter;

  localparam int G     = 300;
  localparam int W     = 6;
  localparam int S     = 2;
  localparam int MAXC  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig = 1'b0;
  logic [W-1:0] freq;
  logic         valid;
  logic         ovf;
  logic [1:0]   dbg;

  int total = 0;
  int bad   = 0;

  // n = posedges since reset release; s_hist[k] = sig_in seen at posedge k (index 0 = reset).
  int n = 0;
  bit s_hist[$];
  int exp_freq = 0;
  bit exp_ovf  = 1'b0;

  freq_meter #(
    .GATE_CYCLES(G),
    .COUNT_W    (W),
    .SYNC_STAGES(S)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .sig_in     (sig),
    .freq_out   (freq),
    .freq_valid (valid),
    .overflow   (ovf),
    .dbg_state_o(dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at n=%0d: got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  function automatic bit s_at(int k);
    if (k <= 0 || k >= s_hist.size()) return 1'b0;
    return s_hist[k];
  endfunction

  // Rising transitions of the input whose synchronized edge lands in posedges last_p-G+1..last_p.
  function automatic int window_edges(int last_p);
    int c = 0;
    for (int p = last_p - G + 1; p <= last_p; p++)
      if (s_at(p - S) && !s_at(p - S - 1)) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    int c;
    if (rst) begin
      n = 0;
      s_hist.delete();
      s_hist.push_back(1'b0);
      exp_freq = 0;
      exp_ovf  = 1'b0;
    end else begin
      n++;
      s_hist.push_back(sig);
    end
    #1;
    if (!rst && n >= S + 1 + G && ((n - S - 1) % G) == 0) begin
      c = window_edges(n);
      exp_freq = (c > MAXC) ? MAXC : c;
      exp_ovf  = (c > MAXC);
      chk("valid_strobe", valid, 1);
    end else begin
      chk("valid_idle", valid, 0);
    end
    chk("freq_out", freq, exp_freq);
    chk("overflow", ovf, exp_ovf);
  end

  task automatic do_reset(input bit level);
    @(negedge clk);
    rst = 1'b1;
    sig = level;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(input bit v, input int cycles);
    sig = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic square(input int hi, input int lo, input int cycles);
    int t = 0;
    while (t < cycles) begin
      sig = 1'b1;
      repeat (hi) @(negedge clk);
      sig = 1'b0;
      repeat (lo) @(negedge clk);
      t += hi + lo;
    end
  endtask

  task automatic wait_n(input int target);
    int guard = 0;
    while (n < target && guard < 10 * G) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_n_reached", (n >= target), 1);
  endtask

  initial begin
    int hi, lo, t;
    // DC low, then DC high from reset
    do_reset(1'b0);
    hold(1'b0, 2 * G + S + 5);
    do_reset(1'b1);
    hold(1'b1, 2 * G + S + 5);

    // Square wave, period 20
    do_reset(1'b0);
    square(10, 10, 3 * G + S + 5);

    // Period 4 saturates the 6-bit counter, then DC windows recover
    do_reset(1'b0);
    square(2, 2, 2 * G);
    hold(1'b0, 2 * G);

    // Single edge landing on the terminal cycle, then on the first cycle of the next window
    do_reset(1'b0);
    wait_n(G);
    hold(1'b1, 2 * G);
    do_reset(1'b0);
    wait_n(G + 1);
    hold(1'b1, 2 * G);

    // Mid-window reset discards the partial window
    do_reset(1'b0);
    square(3, 4, S + 1 + G / 2);
    do_reset(1'b0);
    square(3, 5, G + S + 10);

    // Random high/low times, all >= 2 cycles
    do_reset(1'($urandom_range(0, 1)));
    t = 0;
    while (t < 4 * G) begin
      hi = $urandom_range(2, 9);
      lo = $urandom_range(2, 9);
      square(hi, lo, 1);
      t += hi + lo;
    end
    hold(1'b0, G);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
